// File: rtl/osc_pkg.sv
// Shared constants, state encoding and divisor lookup for the note oscillator.
package osc_pkg;

  localparam int unsigned DIV_W = 19;
  localparam logic [3:0] NOTE_SILENT_MIN = 4'd12;
  localparam logic [7:0] LFSR_SEED_DEFAULT = 8'h7F;

  // Octave-0 period lengths in 12 MHz clocks, C..B.
  localparam logic [DIV_W-1:0] DIV_TABLE [12] = '{
    19'd366939, 19'd346341, 19'd326904, 19'd308555,
    19'd291241, 19'd274889, 19'd259464, 19'd244903,
    19'd231156, 19'd218182, 19'd205938, 19'd194379
  };

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } osc_state_e;

  function automatic logic [DIV_W-1:0] note_divisor(input logic [3:0] note,
                                                    input logic [2:0] octave);
    logic [DIV_W-1:0] base;
    base = '0;
    if (note < NOTE_SILENT_MIN) base = DIV_TABLE[note];
    return base >> octave;
  endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit maximal-length Fibonacci LFSR, advances one step per step_i.
module lfsr8 #(
  parameter logic [7:0] SEED = 8'h7F
) (
  input  logic       clk,
  input  logic       Rst_i,
  input  logic       step_i,
  output logic [7:0] q_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (step_i) lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk) begin
    if (Rst_i) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign q_o = lfsr_q;

endmodule

// File: rtl/note_oscillator.sv
// Note/octave to period divisor, free-running period counter and per-period noise.
module note_oscillator
  import osc_pkg::*;
#(
  parameter int unsigned DIV_W     = osc_pkg::DIV_W,
  parameter logic [7:0]  LFSR_SEED = osc_pkg::LFSR_SEED_DEFAULT
) (
  input  logic             clk,
  input  logic             Rst_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [3:0]       note_i,
  input  logic [2:0]       octave_i,
  output logic [DIV_W-1:0] count_o,
  output logic [DIV_W-1:0] divisor_o,
  output logic [7:0]       Q_o,
  output logic             wrap_o,
  output logic             pending_o
);

  osc_state_e       state_q, state_d;
  logic [DIV_W-1:0] count_q, count_d;
  logic [DIV_W-1:0] divisor_q, divisor_d;
  logic             wrap_q, wrap_d;
  logic             pend_q, pend_d;
  logic [3:0]       pend_note_q, pend_note_d;
  logic [2:0]       pend_oct_q, pend_oct_d;

  logic             step_c;
  logic             at_wrap_c;
  logic [3:0]       sel_note_c;
  logic [2:0]       sel_oct_c;

  assign at_wrap_c  = (count_q == divisor_q - DIV_W'(1));
  // An incoming strobe always beats the queued request.
  assign sel_note_c = load_i ? note_i : pend_note_q;
  assign sel_oct_c  = load_i ? octave_i : pend_oct_q;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    divisor_d   = divisor_q;
    wrap_d      = 1'b0;
    pend_d      = pend_q;
    pend_note_d = pend_note_q;
    pend_oct_d  = pend_oct_q;
    step_c      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (load_i && (note_i < NOTE_SILENT_MIN)) begin
          state_d   = ST_RUN;
          divisor_d = DIV_W'(note_divisor(note_i, octave_i));
          count_d   = '0;
        end
      end
      ST_RUN: begin
        if (en_i && at_wrap_c) begin
          count_d = '0;
          wrap_d  = 1'b1;
          step_c  = 1'b1;
          pend_d  = 1'b0;
          if (load_i || pend_q) begin
            if (sel_note_c >= NOTE_SILENT_MIN) begin
              state_d   = ST_IDLE;
              divisor_d = '0;
            end else begin
              divisor_d = DIV_W'(note_divisor(sel_note_c, sel_oct_c));
            end
          end
        end else begin
          if (en_i) count_d = count_q + DIV_W'(1);
          if (load_i) begin
            pend_d      = 1'b1;
            pend_note_d = note_i;
            pend_oct_d  = octave_i;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Rst_i) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      divisor_q   <= '0;
      wrap_q      <= 1'b0;
      pend_q      <= 1'b0;
      pend_note_q <= '0;
      pend_oct_q  <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      divisor_q   <= divisor_d;
      wrap_q      <= wrap_d;
      pend_q      <= pend_d;
      pend_note_q <= pend_note_d;
      pend_oct_q  <= pend_oct_d;
    end
  end

  lfsr8 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .Rst_i  (Rst_i),
    .step_i (step_c),
    .q_o    (Q_o)
  );

  assign count_o   = count_q;
  assign divisor_o = divisor_q;
  assign wrap_o    = wrap_q;
  assign pending_o = pend_q;

endmodule

// File: tb/tb_note_oscillator.sv
// Directed bench for note_oscillator with hand-computed expected values.
module tb_note_oscillator;

  localparam int unsigned DIV_W = 19;

  logic             clk = 1'b0;
  logic             Rst_i;
  logic             en_i;
  logic             load_i;
  logic [3:0]       note_i;
  logic [2:0]       octave_i;
  logic [DIV_W-1:0] count_o;
  logic [DIV_W-1:0] divisor_o;
  logic [7:0]       Q_o;
  logic             wrap_o;
  logic             pending_o;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  note_oscillator dut (
    .clk       (clk),
    .Rst_i     (Rst_i),
    .en_i      (en_i),
    .load_i    (load_i),
    .note_i    (note_i),
    .octave_i  (octave_i),
    .count_o   (count_o),
    .divisor_o (divisor_o),
    .Q_o       (Q_o),
    .wrap_o    (wrap_o),
    .pending_o (pending_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // One clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_count(input int unsigned target, input int unsigned budget, input string tag);
    int unsigned n;
    n = 0;
    while ((32'(count_o) != target) && (n < budget)) begin
      tick();
      n++;
    end
    chk(tag, 32'(count_o), target);
  endtask

  task automatic load_one(input logic [3:0] note, input logic [2:0] oct);
    load_i   = 1'b1;
    note_i   = note;
    octave_i = oct;
    tick();
    load_i   = 1'b0;
  endtask

  task automatic do_reset();
    Rst_i = 1'b1;
    tick();
    Rst_i = 1'b0;
  endtask

  initial begin
    Rst_i = 1'b1; en_i = 1'b1; load_i = 1'b0; note_i = '0; octave_i = '0;
    tick(); tick();
    Rst_i = 1'b0;
    chk("rst_count", 32'(count_o), 0);
    chk("rst_div",   32'(divisor_o), 0);
    chk("rst_q",     32'(Q_o), 32'h7F);
    chk("rst_wrap",  32'(wrap_o), 0);
    chk("rst_pend",  32'(pending_o), 0);

    // silence request in IDLE is ignored
    load_one(4'd15, 3'd0);
    chk("idle_sil_div",  32'(divisor_o), 0);
    chk("idle_sil_pend", 32'(pending_o), 0);

    // note 9 octave 3: 218182 >> 3 = 27272
    load_one(4'd9, 3'd3);
    chk("start_div",   32'(divisor_o), 27272);
    chk("start_count", 32'(count_o), 0);
    chk("start_wrap",  32'(wrap_o), 0);
    wait_count(27271, 30000, "reach_last");
    chk("last_wrap", 32'(wrap_o), 0);
    tick();
    chk("wrap1_count", 32'(count_o), 0);
    chk("wrap1_pulse", 32'(wrap_o), 1);
    chk("wrap1_q",     32'(Q_o), 32'hFF);
    tick();
    chk("wrap1_drop",  32'(wrap_o), 0);

    // queued request waits for the boundary
    wait_count(100, 200, "reach_100");
    load_one(4'd0, 3'd0);
    chk("q_pend",  32'(pending_o), 1);
    chk("q_div",   32'(divisor_o), 27272);
    chk("q_count", 32'(count_o), 101);
    wait_count(27271, 30000, "reach_last2");
    chk("q_div_hold",  32'(divisor_o), 27272);
    chk("q_pend_hold", 32'(pending_o), 1);
    tick();
    chk("wrap2_div",  32'(divisor_o), 366939);
    chk("wrap2_pend", 32'(pending_o), 0);
    chk("wrap2_q",    32'(Q_o), 32'hFE);
    chk("wrap2_wrap", 32'(wrap_o), 1);

    // load on the wrap edge overrides the queue: 194379>>7 = 1518, 291241>>2 = 72810
    do_reset();
    load_one(4'd11, 3'd7);
    chk("min_div", 32'(divisor_o), 1518);
    wait_count(10, 50, "reach_10");
    load_one(4'd0, 3'd7);
    chk("old_pend", 32'(pending_o), 1);
    wait_count(1517, 2000, "reach_1517");
    load_one(4'd4, 3'd2);
    chk("edge_div",   32'(divisor_o), 72810);
    chk("edge_pend",  32'(pending_o), 0);
    chk("edge_wrap",  32'(wrap_o), 1);
    chk("edge_count", 32'(count_o), 0);

    // queued silence returns to IDLE at the boundary
    do_reset();
    load_one(4'd11, 3'd7);
    load_one(4'd13, 3'd0);
    chk("sil_pend", 32'(pending_o), 1);
    chk("sil_div",  32'(divisor_o), 1518);
    wait_count(1517, 2000, "sil_last");
    tick();
    chk("sil_wrap",  32'(wrap_o), 1);
    chk("sil_div0",  32'(divisor_o), 0);
    chk("sil_cnt0",  32'(count_o), 0);
    chk("sil_pend0", 32'(pending_o), 0);
    chk("sil_q",     32'(Q_o), 32'hFF);
    tick();
    chk("sil_wrap_once", 32'(wrap_o), 0);
    load_one(4'd15, 3'd0);
    tick();
    chk("sil_ign_div",  32'(divisor_o), 0);
    chk("sil_ign_cnt",  32'(count_o), 0);
    chk("sil_ign_pend", 32'(pending_o), 0);

    // freeze with en_i low at count 500
    load_one(4'd11, 3'd7);
    chk("frz_div", 32'(divisor_o), 1518);
    wait_count(500, 600, "frz_reach");
    en_i = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (i == 10) load_one(4'd0, 3'd7);
      else tick();
      if ((i % 10) == 9) begin
        chk("frz_count", 32'(count_o), 500);
        chk("frz_wrap",  32'(wrap_o), 0);
      end
    end
    chk("frz_q",    32'(Q_o), 32'hFF);
    chk("frz_pend", 32'(pending_o), 1);
    en_i = 1'b1;
    tick();
    chk("frz_resume", 32'(count_o), 501);

    // reset mid-run with a request queued, held two cycles
    tick(); tick();
    Rst_i = 1'b1;
    load_i = 1'b1; note_i = 4'd2; octave_i = 3'd1;
    tick();
    chk("mrst1_count", 32'(count_o), 0);
    chk("mrst1_pend",  32'(pending_o), 0);
    tick();
    Rst_i = 1'b0; load_i = 1'b0;
    chk("mrst_count", 32'(count_o), 0);
    chk("mrst_div",   32'(divisor_o), 0);
    chk("mrst_q",     32'(Q_o), 32'h7F);
    chk("mrst_wrap",  32'(wrap_o), 0);
    chk("mrst_pend",  32'(pending_o), 0);
    tick(); tick();
    chk("mrst_idle_cnt", 32'(count_o), 0);
    chk("mrst_idle_div", 32'(divisor_o), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
